// File: rtl/snn_pkg.sv
// Shared types and arithmetic helpers for the spike/current neuron pair.
//  - snn_state_e : front-end sequencer states
//  - cur_t       : CUR_W-bit synaptic current word
//  - sat_add     : saturating accumulate of a weight into the current
//  - decay_step  : one exponential decay step that always converges to 0
package snn_pkg;

    localparam int unsigned CUR_W   = 8;
    localparam logic [CUR_W-1:0] CUR_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DECAY = 2'd2
    } snn_state_e;

    typedef logic [CUR_W-1:0] cur_t;

    // Add in CUR_W+1 bits and clamp on carry-out.
    function automatic cur_t sat_add(input cur_t a, input cur_t b);
        logic [CUR_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CUR_W] ? CUR_MAX : sum[CUR_W-1:0];
    endfunction

    // Subtract a >> shift; once that rounds to zero, step by one so the value reaches 0.
    function automatic cur_t decay_step(input cur_t a, input int unsigned shift);
        cur_t d;
        d = a >> shift;
        if (d != '0) begin
            return a - d;
        end
        return a - CUR_W'(a != '0);
    endfunction

endpackage

// File: rtl/synapse_drive_if.sv
// Bus bundle between the spike source / weight programmer and synapse_drive.
//  spike_in  : one-cycle spike pulses, bit i = channel i
//  w_wr_*    : weight write strobe, index, value
//  ovf_clr   : clears the sticky overflow flag
//  current   : synaptic current to the neuron
//  busy      : sequencer active or spikes pending
//  ovf       : sticky lost-spike flag
interface synapse_drive_if #(
    parameter int unsigned N_SYN = 4
);
    import snn_pkg::*;

    localparam int unsigned AW = $clog2(N_SYN);

    logic [N_SYN-1:0] spike_in;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_addr;
    cur_t             w_wr_data;
    logic             ovf_clr;
    cur_t             current;
    logic             busy;
    logic             ovf;

    modport master (
        output spike_in, w_wr_en, w_wr_addr, w_wr_data, ovf_clr,
        input  current, busy, ovf
    );

    modport slave (
        input  spike_in, w_wr_en, w_wr_addr, w_wr_data, ovf_clr,
        output current, busy, ovf
    );

endinterface

// File: rtl/prio_enc.sv
// Lowest-set-bit finder.
//  req   : request mask
//  idx   : index of the lowest set bit (0 when none)
//  valid : any bit of req set
module prio_enc #(
    parameter int unsigned N  = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (req[i] && !valid) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/synapse_drive.sv
// Spike-to-current front end: each spike on channel i adds weight[i] into a saturating
// accumulator through one shared adder; the accumulator decays on a prescaled tick.
//  clk  : system clock, rising edge
//  rst  : synchronous reset, active-high
//  bus  : synapse_drive_if slave (spikes, weight writes, ovf_clr in; current, busy, ovf out)
module synapse_drive
    import snn_pkg::*;
#(
    parameter int unsigned N_SYN       = 4,
    parameter int unsigned DECAY_DIV   = 16,
    parameter int unsigned DECAY_SHIFT = 3
) (
    input  logic             clk,
    input  logic             rst,
    synapse_drive_if.slave   bus
);

    localparam int unsigned IW = $clog2(N_SYN);
    localparam int unsigned PW = $clog2(DECAY_DIV);

    snn_state_e       state_q, state_d;
    logic [N_SYN-1:0] pending_q, pending_d;
    logic [N_SYN-1:0] clr_bit, hi_mask, pe_req;
    logic [IW-1:0]    idx_q, idx_d, pe_idx;
    logic             pe_valid;
    cur_t             acc_q, acc_d;
    cur_t             weight_q [N_SYN];
    logic [PW-1:0]    presc_q;
    logic             presc_wrap;
    logic             decay_due_q;
    logic             ovf_q, ovf_set;
    logic             busy_q;

    // Pending mask update; a spike landing on a still-pending bit is lost and flagged.
    always_comb begin
        clr_bit   = (state_q == SCAN) ? (N_SYN'(1) << idx_q) : '0;
        pending_d = (pending_q & ~clr_bit) | bus.spike_in;
        ovf_set   = |(bus.spike_in & pending_q & ~clr_bit);
    end

    // Channels strictly above the one being summed; lower late arrivals wait for the next pass.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < int'(N_SYN); i++) begin
            hi_mask[i] = (IW'(i) > idx_q);
        end
    end

    // IDLE picks the first channel of a pass; SCAN picks the next one above the current index.
    assign pe_req = (state_q == SCAN) ? (pending_d & hi_mask) : pending_q;

    prio_enc #(.N(N_SYN)) u_prio_enc (
        .req   (pe_req),
        .idx   (pe_idx),
        .valid (pe_valid)
    );

    // Sequencer next-state and accumulator datapath.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        unique case (state_q)
            IDLE: begin
                if (decay_due_q) begin
                    state_d = DECAY;
                end else if (pe_valid) begin
                    state_d = SCAN;
                    idx_d   = pe_idx;
                end
            end
            SCAN: begin
                acc_d = sat_add(acc_q, weight_q[idx_q]);
                if (pe_valid) begin
                    idx_d = pe_idx;
                end else begin
                    state_d = IDLE;
                end
            end
            DECAY: begin
                acc_d   = decay_step(acc_q, DECAY_SHIFT);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign presc_wrap = (presc_q == PW'(DECAY_DIV - 1));

    // State, mask, accumulator, prescaler and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pending_q   <= '0;
            acc_q       <= '0;
            presc_q     <= '0;
            decay_due_q <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            acc_q     <= acc_d;
            presc_q   <= presc_wrap ? '0 : presc_q + PW'(1);
            // A new request on the same edge as a decay execution starts the next period.
            if (presc_wrap) begin
                decay_due_q <= 1'b1;
            end else if (state_q == DECAY) begin
                decay_due_q <= 1'b0;
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_q <= 1'b0;
            end
            busy_q <= (state_d != IDLE) || (pending_d != '0);
        end
    end

    // Weight flop array; indices with no matching entry are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N_SYN); i++) begin
                weight_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_SYN); i++) begin
                if (bus.w_wr_en && (bus.w_wr_addr == IW'(i))) begin
                    weight_q[i] <= bus.w_wr_data;
                end
            end
        end
    end

    assign bus.current = acc_q;
    assign bus.busy    = busy_q;
    assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_synapse_drive.sv
// Directed and randomized bench for synapse_drive with a reference model of the
// accumulate / saturate / decay rules.
module tb_synapse_drive;
    import snn_pkg::*;

    localparam int unsigned N_SYN       = 4;
    localparam int unsigned DECAY_DIV   = 64;
    localparam int unsigned DECAY_SHIFT = 3;
    localparam int unsigned AW          = $clog2(N_SYN);

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   wv [N_SYN];

    synapse_drive_if #(.N_SYN(N_SYN)) bus ();

    synapse_drive #(
        .N_SYN       (N_SYN),
        .DECAY_DIV   (DECAY_DIV),
        .DECAY_SHIFT (DECAY_SHIFT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    function automatic int ref_add(input int a, input int w);
        return (a + w > 255) ? 255 : a + w;
    endfunction

    function automatic int ref_decay(input int a);
        int d;
        d = a / (1 << DECAY_SHIFT);
        if (d > 0) return a - d;
        return (a > 0) ? a - 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.spike_in = '0;
        bus.w_wr_en  = 1'b0;
        bus.ovf_clr  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic write_w(input int i, input int v);
        bus.w_wr_en   = 1'b1;
        bus.w_wr_addr = AW'(i);
        bus.w_wr_data = 8'(v);
        tick();
        bus.w_wr_en = 1'b0;
    endtask

    // Returns #1 after the edge that samples the spike (edge k).
    task automatic spike(input logic [N_SYN-1:0] m);
        bus.spike_in = m;
        tick();
        bus.spike_in = '0;
    endtask

    task automatic load_weights(input int a, input int b, input int c, input int d);
        wv[0] = a; wv[1] = b; wv[2] = c; wv[3] = d;
        for (int i = 0; i < int'(N_SYN); i++) write_w(i, wv[i]);
    endtask

    initial begin
        int acc_m;
        int prev;
        int cnt;
        int steps;
        logic [N_SYN-1:0] mm;

        rst           = 1'b1;
        bus.spike_in  = '0;
        bus.w_wr_en   = 1'b0;
        bus.w_wr_addr = '0;
        bus.w_wr_data = '0;
        bus.ovf_clr   = 1'b0;

        // Reset and idle
        do_reset();
        check("reset_current", bus.current, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_ovf", bus.ovf, 0);
        for (int c = 0; c < 40; c++) begin
            tick();
            check("idle_current", bus.current, 0);
            check("idle_busy", bus.busy, 0);
            check("idle_ovf", bus.ovf, 0);
        end

        // Single spike latency
        do_reset();
        write_w(0, 40);
        spike(4'b0001);
        check("single_busy_k", bus.busy, 1);
        tick();
        check("single_current_k1", bus.current, 0);
        tick();
        check("single_current_k2", bus.current, 40);
        tick();
        check("single_busy_k3", bus.busy, 0);

        // Four simultaneous spikes scanned lowest channel first
        do_reset();
        load_weights(10, 20, 30, 40);
        spike(4'b1111);
        tick();
        acc_m = 0;
        for (int i = 0; i < int'(N_SYN); i++) begin
            tick();
            acc_m = ref_add(acc_m, wv[i]);
            check("burst_step", bus.current, acc_m);
        end
        tick();
        check("burst_busy", bus.busy, 0);

        // Spike above the active index joins the same pass
        do_reset();
        load_weights(10, 20, 30, 40);
        spike(4'b0001);
        tick();
        bus.spike_in = 4'b0100;
        tick();
        bus.spike_in = '0;
        check("join_hi_first", bus.current, 10);
        tick();
        check("join_hi_second", bus.current, 40);
        tick();
        check("join_hi_busy", bus.busy, 0);

        // Spike below the active index waits for the next pass
        do_reset();
        load_weights(10, 20, 30, 40);
        spike(4'b0100);
        tick();
        bus.spike_in = 4'b0001;
        tick();
        bus.spike_in = '0;
        check("join_lo_first", bus.current, 30);
        check("join_lo_busy", bus.busy, 1);
        tick();
        check("join_lo_gap", bus.current, 30);
        tick();
        check("join_lo_second", bus.current, 40);
        check("join_lo_ovf", bus.ovf, 0);

        // Weight written during its own summation is not seen until the next spike
        do_reset();
        write_w(0, 40);
        spike(4'b0001);
        tick();
        bus.w_wr_en   = 1'b1;
        bus.w_wr_addr = AW'(0);
        bus.w_wr_data = 8'd99;
        tick();
        bus.w_wr_en = 1'b0;
        check("wr_same_cycle_old", bus.current, 40);
        tick();
        spike(4'b0001);
        tick();
        tick();
        check("wr_same_cycle_new", bus.current, 139);

        // Merged spike sets ovf; saturation; sticky clear; set beats clear
        do_reset();
        write_w(1, 200);
        bus.spike_in = 4'b0010;
        tick();
        check("ovf_first_edge", bus.ovf, 0);
        tick();
        bus.spike_in = '0;
        check("ovf_set", bus.ovf, 1);
        tick();
        check("ovf_merged_current", bus.current, 200);
        tick();
        check("ovf_sticky", bus.ovf, 1);
        spike(4'b0010);
        tick();
        tick();
        check("sat_first", bus.current, 255);
        tick();
        spike(4'b0010);
        tick();
        tick();
        check("sat_hold", bus.current, 255);
        check("ovf_still_set", bus.ovf, 1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("ovf_cleared", bus.ovf, 0);
        tick();
        bus.spike_in = 4'b0010;
        tick();
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr  = 1'b0;
        bus.spike_in = '0;
        check("ovf_set_wins", bus.ovf, 1);

        // Reset in the middle of a scan
        do_reset();
        load_weights(10, 20, 30, 40);
        spike(4'b0111);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midscan_rst_current", bus.current, 0);
        check("midscan_rst_busy", bus.busy, 0);
        for (int c = 0; c < 6; c++) begin
            tick();
            check("midscan_no_resume_cur", bus.current, 0);
            check("midscan_no_resume_busy", bus.busy, 0);
        end

        // Randomized weights and spike masks against the reference model
        for (int t = 0; t < 16; t++) begin
            do_reset();
            load_weights($urandom_range(0, 120), $urandom_range(0, 120),
                         $urandom_range(0, 120), $urandom_range(0, 120));
            acc_m = 0;
            for (int b = 0; b < 2; b++) begin
                mm = N_SYN'($urandom_range(1, 15));
                spike(mm);
                tick();
                for (int i = 0; i < int'(N_SYN); i++) begin
                    if (mm[i]) begin
                        tick();
                        acc_m = ref_add(acc_m, wv[i]);
                        check("rand_step", bus.current, acc_m);
                    end
                end
                tick();
                check("rand_busy", bus.busy, 0);
                check("rand_ovf", bus.ovf, 0);
            end
        end

        // Exponential decay from 100 down to 0, one step per prescaler period
        do_reset();
        write_w(0, 100);
        spike(4'b0001);
        tick();
        tick();
        check("decay_start", bus.current, 100);
        prev  = 100;
        steps = 0;
        while (prev != 0 && steps < 40) begin
            cnt = 0;
            while (int'(bus.current) == prev && cnt < int'(DECAY_DIV) + 4) begin
                tick();
                cnt++;
            end
            check("decay_value", bus.current, ref_decay(prev));
            if (steps > 0) check("decay_interval", cnt, DECAY_DIV);
            prev = ref_decay(prev);
            steps++;
        end
        for (int c = 0; c < 2 * int'(DECAY_DIV); c++) tick();
        check("decay_floor", bus.current, 0);
        check("decay_busy", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
